// File: rtl/tlc_multi_phase.sv
// Multi-approach traffic-light controller: round-robin actuated green,
// yellow and all-red clearance, min/max green with gap-out, flashing yellow.
module tlc_multi_phase #(
    parameter int NPH       = 4,
    parameter int CW        = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YEL_T     = 2,
    parameter int ALLRED_T  = 1,
    localparam int PW = (NPH > 1) ? $clog2(NPH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NPH-1:0]     req,
    input  logic               flash,
    output logic [2*NPH-1:0]   lights,
    output logic [PW-1:0]      phase,
    output logic [1:0]         state_o,
    output logic [NPH-1:0]     pend
);

    typedef enum logic [1:0] {
        S_ALLRED = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10,
        S_FLASH  = 2'b11
    } state_t;

    localparam logic [CW:0] GMIN = (CW+1)'(GREEN_MIN);
    localparam logic [CW:0] GMAX = (CW+1)'(GREEN_MAX);
    localparam logic [CW:0] YT   = (CW+1)'(YEL_T);
    localparam logic [CW:0] ART  = (CW+1)'(ALLRED_T);

    state_t         state, state_nx;
    logic [PW-1:0]  phase_nx, nxt;
    logic [CW-1:0]  timer, timer_nx;
    logic [CW:0]    tcount;
    logic [NPH-1:0] pend_nx, cur, nonred;
    logic           blink, blink_nx;
    logic           other, req_cur;

    assign tcount = (CW+1)'(timer) + (CW+1)'(1);

    always_comb begin
        cur = '0;
        for (int i = 0; i < NPH; i++)
            cur[i] = (phase == PW'(i));
    end

    assign other   = (|(pend & ~cur)) | flash;
    assign req_cur = |(req & cur);

    // Later (smaller k) matches overwrite earlier ones: nearest pending wins.
    always_comb begin
        nxt = (int'(phase) == NPH - 1) ? '0 : phase + 1'b1;
        for (int k = NPH; k >= 1; k--)
            for (int i = 0; i < NPH; i++)
                if (pend[i] && ((int'(phase) + k) % NPH == i))
                    nxt = PW'(i);
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        blink_nx = blink;
        unique case (state)
            S_ALLRED: begin
                if (tick && tcount >= ART) begin
                    if (flash) begin
                        state_nx = S_FLASH;
                        blink_nx = 1'b1;
                    end else begin
                        state_nx = S_GREEN;
                        phase_nx = nxt;
                    end
                end
            end
            S_GREEN: begin
                if (tick && other &&
                    (tcount >= GMAX || (tcount >= GMIN && !req_cur)))
                    state_nx = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && tcount >= YT)
                    state_nx = S_ALLRED;
            end
            S_FLASH: begin
                // Leaving flash does not wait for the timebase.
                if (!flash) begin
                    state_nx = S_ALLRED;
                    blink_nx = 1'b0;
                end else if (tick) begin
                    blink_nx = ~blink;
                end
            end
        endcase
    end

    always_comb begin
        if (state_nx != state)
            timer_nx = '0;
        else if (tick && timer != '1)
            timer_nx = timer + 1'b1;
        else
            timer_nx = timer;
    end

    assign pend_nx = (pend | req) & ~((state == S_GREEN) ? cur : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ALLRED;
            phase <= PW'(NPH - 1);
            timer <= '0;
            pend  <= '0;
            blink <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            timer <= timer_nx;
            pend  <= pend_nx;
            blink <= blink_nx;
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < NPH; i++) begin
            if (state == S_FLASH)
                lights[2*i +: 2] = blink ? 2'b01 : 2'b00;
            else if (cur[i] && state == S_GREEN)
                lights[2*i +: 2] = 2'b10;
            else if (cur[i] && state == S_YELLOW)
                lights[2*i +: 2] = 2'b01;
        end
    end

    assign state_o = state;

    always_comb begin
        nonred = '0;
        for (int i = 0; i < NPH; i++)
            nonred[i] = |lights[2*i +: 2];
    end

    // Conflict and green-entry safety checks.
    a_one_lamp: assert property (@(posedge clk) disable iff (rst)
        (state != S_FLASH) |-> $onehot0(nonred));
    a_green_entry: assert property (@(posedge clk) disable iff (rst)
        (state == S_GREEN && $past(state) != S_GREEN)
            |-> $past(state) == S_ALLRED);

endmodule
